// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared width, opcode and state definitions for the sequential multiplier
package mul_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_add32.sv
// rtl/mul_add32.sv - combinational 32-bit adder with carry-out for the partial-sum path
module mul_add32 (
    input  logic [31:0] i_data_a,
    input  logic [31:0] i_data_b,
    output logic [31:0] o_data,
    output logic        o_carry
);

    assign {o_carry, o_data} = {1'b0, i_data_a} + {1'b0, i_data_b};

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, one result per 34 cycles
module mul_seq
    import mul_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_data_a,
    input  logic [XLEN-1:0] i_data_b,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_data
);

    mul_state_e        state;
    mul_state_e        state_nxt;
    mul_op_e           op_in;
    mul_op_e           op_q;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              sign;
    logic [CNT_W-1:0]  cnt;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   add_b;
    logic [XLEN-1:0]   sum;
    logic              carry;
    logic [2*XLEN-1:0] prod;

    // Magnitudes are multiplied unsigned; the sign is reapplied in FIX.
    assign op_in = mul_op_e'(i_op);
    assign a_neg = i_data_a[XLEN-1] & ((op_in == MULH) | (op_in == MULHSU));
    assign b_neg = i_data_b[XLEN-1] & (op_in == MULH);
    assign add_b = lo[0] ? mcand : '0;
    assign prod  = sign ? (~{hi, lo} + 64'd1) : {hi, lo};

    mul_add32 u_add (
        .i_data_a (hi),
        .i_data_b (add_b),
        .o_data   (sum),
        .o_carry  (carry)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(XLEN - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == CALC) || (state == FIX);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q    <= MUL;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op_q  <= op_in;
                        mcand <= a_neg ? (~i_data_a + 32'd1) : i_data_a;
                        lo    <= b_neg ? (~i_data_b + 32'd1) : i_data_b;
                        sign  <= a_neg ^ b_neg;
                        hi    <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    {hi, lo} <= {carry, sum, lo[XLEN-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                end
                FIX: begin
                    o_data  <= (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    o_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
